// File: rtl/tlp_arb_pkg.sv
// Types and helpers shared by the TLP TX arbiter and its rotating picker.
package tlp_arb_pkg;

  localparam int ARB_MAX_SRC  = 8;
  localparam int ARB_IDX_BITS = $clog2(ARB_MAX_SRC);

  typedef logic [ARB_IDX_BITS-1:0] SrcIndex;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ArbState;

  typedef tlp_xcvr_pkg::uint64 uint64;

  // Next source index after idx, wrapping at numSrc.
  function automatic SrcIndex wrapInc(input SrcIndex idx, input int numSrc);
    SrcIndex nxt;
    nxt = idx + SrcIndex'(1);
    if (int'(idx) + 1 >= numSrc) nxt = '0;
    return nxt;
  endfunction

endpackage

// File: rtl/tlp_xcvr_pkg.sv
// Shared transceiver-side datapath types used by the TLP generation and TX blocks.
package tlp_xcvr_pkg;

  typedef logic [63:0] uint64;

endpackage

// File: rtl/tlp_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above rrPtr_i,
// scanning upward modulo NUM_SRC.
module tlp_arb_rr_pick #(
  parameter int NUM_SRC  = 2,
  parameter int SRC_BITS = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req_i,
  input  logic [SRC_BITS-1:0] rrPtr_i,
  output logic                found_o,
  output logic [SRC_BITS-1:0] winner_o
);

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    int idx;
    found_o  = 1'b0;
    winner_o = '0;
    idx      = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = (int'(rrPtr_i) + k) % NUM_SRC;
      if (req_i[idx[SRC_BITS-1:0]]) begin
        found_o  = 1'b1;
        winner_o = idx[SRC_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_SRC TLP sources onto one TX stream.
// Define TLP_ARB_PRIO0_EN to give source 0 strict priority at packet boundaries.
module tlp_tx_arbiter
  import tlp_arb_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int SRC_BITS = $clog2(NUM_SRC)
) (
  input  logic                  pcieClk_in,
  input  logic                  pcieRstN_in,
  input  uint64 [NUM_SRC-1:0]   srcData_in,
  input  logic  [NUM_SRC-1:0]   srcValid_in,
  output logic  [NUM_SRC-1:0]   srcReady_out,
  input  logic  [NUM_SRC-1:0]   srcSOP_in,
  input  logic  [NUM_SRC-1:0]   srcEOP_in,
  output uint64                 txData_out,
  output logic                  txValid_out,
  input  logic                  txReady_in,
  output logic                  txSOP_out,
  output logic                  txEOP_out,
  output logic  [SRC_BITS-1:0]  grant_out,
  output logic                  busy_out,
  output logic                  protoErr_out
);

  ArbState             state_q, state_d;
  logic [SRC_BITS-1:0] grant_q, grant_d;
  logic [SRC_BITS-1:0] rrPtr_q, rrPtr_d;
  logic                started_q, started_d;

  logic [NUM_SRC-1:0]  req, pickReq;
  logic [SRC_BITS-1:0] nextPtr, pickPtr, pickWinner, winner;
  logic                pickFound, found;
  logic                busy, beatHs, eopHs, sopErr, strayErr;

  assign busy   = (state_q == BUSY);
  assign req    = srcValid_in & srcSOP_in;
  assign beatHs = busy & srcValid_in[grant_q] & txReady_in;
  assign eopHs  = beatHs & srcEOP_in[grant_q];

`ifdef TLP_ARB_PRIO0_EN
  // Source 0 sits outside the rotation, so its grants leave the pointer alone.
  assign pickReq = {req[NUM_SRC-1:1], 1'b0};
  assign nextPtr = (grant_q == '0) ? rrPtr_q
                                   : SRC_BITS'(wrapInc(SrcIndex'(grant_q), NUM_SRC));
  assign found   = req[0] | pickFound;
  assign winner  = req[0] ? '0 : pickWinner;
`else
  assign pickReq = req;
  assign nextPtr = SRC_BITS'(wrapInc(SrcIndex'(grant_q), NUM_SRC));
  assign found   = pickFound;
  assign winner  = pickWinner;
`endif

  // At an EOP boundary the re-grant already sees the advanced pointer.
  assign pickPtr = busy ? nextPtr : rrPtr_q;
  assign rrPtr_d = eopHs ? nextPtr : rrPtr_q;

  tlp_arb_rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .SRC_BITS (SRC_BITS)
  ) u_pick (
    .req_i    (pickReq),
    .rrPtr_i  (pickPtr),
    .found_o  (pickFound),
    .winner_o (pickWinner)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    started_d = started_q;
    case (state_q)
      IDLE: begin
        started_d = 1'b0;
        if (found) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (beatHs) begin
          started_d = 1'b1;
          if (srcEOP_in[grant_q]) begin
            started_d = 1'b0;
            if (found) grant_d = winner;
            else       state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrPtr_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      started_q <= started_d;
    end
  end

  always_comb begin
    txValid_out  = 1'b0;
    txData_out   = '0;
    txSOP_out    = 1'b0;
    txEOP_out    = 1'b0;
    srcReady_out = '0;
    if (busy) begin
      txValid_out           = srcValid_in[grant_q];
      txData_out            = srcData_in[grant_q];
      txSOP_out             = srcSOP_in[grant_q];
      txEOP_out             = srcEOP_in[grant_q];
      srcReady_out[grant_q] = txReady_in;
    end
  end

  // Any source other than the one owning the link must open with SOP.
  always_comb begin
    strayErr = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (srcValid_in[i] && !srcSOP_in[i] && !(busy && (int'(grant_q) == i)))
        strayErr = 1'b1;
    end
  end

  assign sopErr       = beatHs & srcSOP_in[grant_q] & started_q;
  assign protoErr_out = pcieRstN_in & (sopErr | strayErr);
  assign grant_out    = grant_q;
  assign busy_out     = busy;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Randomized scoreboard bench for tlp_tx_arbiter against a packet-level reference model.
// Builds with NUM_SRC=3 and strict source-0 priority when TLP_ARB_PRIO0_EN is defined.
module tb_tlp_tx_arbiter;
  import tlp_arb_pkg::*;

`ifdef TLP_ARB_PRIO0_EN
  localparam int NS   = 3;
  localparam bit PRIO = 1'b1;
`else
  localparam int NS   = 2;
  localparam bit PRIO = 1'b0;
`endif
  localparam int SB = $clog2(NS);

  typedef struct {
    logic          busy;
    int            grant;
    logic          txValid;
    logic [NS-1:0] ready;
    logic          err;
  } StsRec;

  typedef struct {
    uint64 data;
    logic  sop;
    logic  eop;
  } BeatRec;

  logic           clk  = 1'b0;
  logic           rstN = 1'b0;
  uint64 [NS-1:0] srcData;
  logic  [NS-1:0] srcValid, srcReady, srcSOP, srcEOP;
  uint64          txData;
  logic           txValid, txReady, txSOP, txEOP;
  logic  [SB-1:0] grant;
  logic           busy, protoErr;

  int     nCmp = 0;
  int     nFail = 0;
  StsRec  stsQ[$];
  BeatRec beatQ[$];

  // Reference model: current link owner (-1 when idle), first beat taken, rotation pointer.
  int ownr      = -1;
  bit strt      = 1'b0;
  int rr        = 0;
  int lastGrant = 0;

  bit          srcAct[NS];
  int          len[NS], beat[NS], seq[NS];
  logic [31:0] salt[NS];
  int          startPct, validPct, readyPct, errPct, fixLen;
  bit          allowNew, drainMode;

  always #4 clk = ~clk;

  tlp_tx_arbiter #(.NUM_SRC(NS)) dut (
    .pcieClk_in   (clk),
    .pcieRstN_in  (rstN),
    .srcData_in   (srcData),
    .srcValid_in  (srcValid),
    .srcReady_out (srcReady),
    .srcSOP_in    (srcSOP),
    .srcEOP_in    (srcEOP),
    .txData_out   (txData),
    .txValid_out  (txValid),
    .txReady_in   (txReady),
    .txSOP_out    (txSOP),
    .txEOP_out    (txEOP),
    .grant_out    (grant),
    .busy_out     (busy),
    .protoErr_out (protoErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCmp++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int refPick(input logic [NS-1:0] rq, input int ptr);
    if (PRIO && rq[0]) return 0;
    for (int k = 0; k < NS; k++) begin
      int j;
      j = (ptr + k) % NS;
      if (!(PRIO && j == 0) && rq[j]) return j;
    end
    return -1;
  endfunction

  // Predict this cycle's outputs from the driven inputs, queue them, then advance past the edge.
  task automatic modelStep();
    StsRec         s;
    BeatRec        b;
    logic [NS-1:0] rq;
    bit            hs;
    rq        = srcValid & srcSOP;
    hs        = 1'b0;
    s.busy    = (ownr >= 0);
    s.grant   = lastGrant;
    s.txValid = 1'b0;
    s.ready   = '0;
    s.err     = 1'b0;
    if (ownr >= 0) begin
      s.txValid     = srcValid[ownr];
      s.ready[ownr] = txReady;
      hs            = srcValid[ownr] && txReady;
      if (hs) begin
        b.data = srcData[ownr];
        b.sop  = srcSOP[ownr];
        b.eop  = srcEOP[ownr];
        beatQ.push_back(b);
        if (srcSOP[ownr] && strt) s.err = 1'b1;
      end
    end
    for (int j = 0; j < NS; j++)
      if (j != ownr && srcValid[j] && !srcSOP[j]) s.err = 1'b1;
    stsQ.push_back(s);

    if (ownr < 0) begin
      ownr = refPick(rq, rr);
      strt = 1'b0;
    end else if (hs) begin
      strt = 1'b1;
      if (srcEOP[ownr]) begin
        if (!PRIO || ownr != 0) rr = (ownr + 1) % NS;
        strt = 1'b0;
        ownr = refPick(rq, rr);
      end
    end
    if (ownr >= 0) lastGrant = ownr;
  endtask

  task automatic modelReset();
    ownr = -1; strt = 1'b0; rr = 0; lastGrant = 0;
    for (int i = 0; i < NS; i++) begin
      srcAct[i] = 1'b0; beat[i] = 0; len[i] = 1;
    end
    srcValid = '0; srcSOP = '0; srcEOP = '0; srcData = '0; txReady = 1'b0;
  endtask

  // One cycle of source behaviour, called right after a falling edge.
  task automatic driveCycle();
    bit othersAct;
    bit newOk;
    for (int i = 0; i < NS; i++) begin
      othersAct = 1'b0;
      for (int j = 0; j < NS; j++) if (j != i && srcAct[j]) othersAct = 1'b1;
      srcValid[i] = 1'b0; srcSOP[i] = 1'b0; srcEOP[i] = 1'b0; srcData[i] = '0;
      newOk = allowNew ? ($urandom_range(0, 99) < startPct) : (drainMode && i == ownr && othersAct);
      if (!srcAct[i] && newOk) begin
        srcAct[i] = 1'b1;
        beat[i]   = 0;
        len[i]    = (fixLen > 0) ? fixLen : int'($urandom_range(1, 4));
        if (!allowNew) len[i] = 1;
        seq[i]++;
        salt[i]   = $urandom;
      end
      if (srcAct[i]) begin
        srcValid[i] = ($urandom_range(0, 99) < validPct);
        srcSOP[i]   = (beat[i] == 0);
        srcEOP[i]   = (beat[i] == len[i] - 1);
        srcData[i]  = {8'(i), 8'(seq[i]), 8'(beat[i]), 8'hA5, salt[i]};
        if (beat[i] > 0 && $urandom_range(0, 99) < errPct) srcSOP[i] = 1'b1;
      end else if (i != ownr && $urandom_range(0, 99) < errPct) begin
        srcValid[i] = 1'b1;
        srcData[i]  = {32'hDEAD0000, $urandom};
      end
    end
    txReady = ($urandom_range(0, 99) < readyPct);
    #1;
    modelStep();
    for (int i = 0; i < NS; i++) begin
      if (srcAct[i] && srcValid[i] && srcReady[i]) begin
        if (beat[i] == len[i] - 1) srcAct[i] = 1'b0;
        else                       beat[i]++;
      end
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      driveCycle();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_txValid"}, 64'(txValid), 64'd0);
    checkOutput({tag, "_txData"}, txData, 64'd0);
    checkOutput({tag, "_txSOP"}, 64'(txSOP), 64'd0);
    checkOutput({tag, "_txEOP"}, 64'(txEOP), 64'd0);
    checkOutput({tag, "_srcReady"}, 64'(srcReady), 64'd0);
    checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_protoErr"}, 64'(protoErr), 64'd0);
  endtask

  // Monitor: pops one status record per modelled cycle and one beat per observed TX handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stsQ.size() > 0) begin
        StsRec  s;
        BeatRec b;
        s = stsQ.pop_front();
        checkOutput("busy", 64'(busy), 64'(s.busy));
        checkOutput("grant", 64'(grant), 64'(s.grant));
        checkOutput("txValid", 64'(txValid), 64'(s.txValid));
        checkOutput("srcReady", 64'(srcReady), 64'(s.ready));
        checkOutput("protoErr", 64'(protoErr), 64'(s.err));
        if (!s.busy) checkOutput("idleData", txData, 64'd0);
        if (txValid && txReady) begin
          if (beatQ.size() == 0) begin
            checkOutput("unexpectedBeat", 64'(txValid), 64'd0);
          end else begin
            b = beatQ.pop_front();
            checkOutput("beatData", txData, b.data);
            checkOutput("beatSOP", 64'(txSOP), 64'(b.sop));
            checkOutput("beatEOP", 64'(txEOP), 64'(b.eop));
          end
        end
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < NS; i++) seq[i] = 0;
    modelReset();
    allowNew = 1'b1; drainMode = 1'b0;

    // Reset held with stray non-SOP valids present: every output must stay 0.
    rstN = 1'b0; srcValid = '1; txReady = 1'b1;
    #10;
    $display("[TB] power-on reset checks");
    checkResetOutputs("por");
    modelReset();
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;

    $display("[TB] saturated 2-beat packets");
    startPct = 100; validPct = 100; readyPct = 100; errPct = 0; fixLen = 2;
    applyStimulus(40);

    $display("[TB] saturated single-beat packets");
    fixLen = 1;
    applyStimulus(40);

    $display("[TB] 3-beat packets with throttled ready");
    fixLen = 3; readyPct = 50;
    applyStimulus(60);

    $display("[TB] random traffic with framing errors");
    fixLen = 0; startPct = 30; validPct = 80; readyPct = 70; errPct = 3;
    applyStimulus(1500);

    $display("[TB] reset in the middle of a packet");
    errPct = 0; validPct = 100; readyPct = 60; startPct = 60;
    w = 0;
    while (!(ownr >= 0 && strt) && w < 200) begin
      @(negedge clk);
      driveCycle();
      w++;
    end
    nCmp++;
    if (!(ownr >= 0 && strt)) begin
      nFail++;
      $display("[TB] FAIL midPacketWait: no packet in flight after %0d cycles, required one", w);
    end
    @(negedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checkResetOutputs("midpkt");
    modelReset();
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;

    $display("[TB] random traffic after reset");
    startPct = 30; validPct = 85; readyPct = 75; errPct = 2;
    applyStimulus(500);

    $display("[TB] draining sources");
    allowNew = 1'b0; drainMode = 1'b1; validPct = 100; readyPct = 100; errPct = 0;
    w = 0;
    while (w < 400) begin
      bit anyAct;
      anyAct = 1'b0;
      for (int i = 0; i < NS; i++) if (srcAct[i]) anyAct = 1'b1;
      if (!anyAct) break;
      @(negedge clk);
      driveCycle();
      w++;
    end
    nCmp++;
    if (w >= 400) begin
      nFail++;
      $display("[TB] FAIL drainTimeout: sources still active after %0d cycles, required 0 active", w);
    end
    applyStimulus(2);
    @(negedge clk);
    #3;
    checkOutput("beatQueueEmpty", 64'(beatQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/tlp_tx_arbiter.md
Name: tlp_tx_arbiter

Overview:
Shares the single PCIe TX TLP stream (64-bit, SOP/EOP framed, valid/ready) between NUM_SRC independent TLP sources, such as completion generation, F2C DMA writes and interrupt messages. Arbitration is packet-atomic round-robin: once a source is granted, it keeps the link until its EOP beat is accepted. The block sits between the TLP-generating units and the PCIe core TX interface.

Parameters:
NUM_SRC, 2, number of requesting TLP sources (2..8)
SRC_BITS, $clog2(NUM_SRC), width of the source index (derived; do not override)

Ports:
pcieClk_in  in  1  125MHz core clock; all logic is on its rising edge
pcieRstN_in  in  1  asynchronous active-low reset
srcData_in  in  NUM_SRC x 64  per-source TLP beat data
srcValid_in  in  NUM_SRC  per-source beat valid
srcReady_out  out  NUM_SRC  per-source beat accepted
srcSOP_in  in  NUM_SRC  per-source start-of-packet
srcEOP_in  in  NUM_SRC  per-source end-of-packet
txData_out  out  64  merged TLP data to the PCIe core
txValid_out  out  1  merged valid
txReady_in  in  1  PCIe core ready
txSOP_out  out  1  merged SOP
txEOP_out  out  1  merged EOP
grant_out  out  SRC_BITS  index of the currently granted source
busy_out  out  1  a packet is in flight
protoErr_out  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, rrPtr=0; every output is 0.
- A request from source i is srcValid_in[i] & srcSOP_in[i].
- States:
  - IDLE: if any request exists, pick the first requester scanning from rrPtr upward modulo NUM_SRC. Register grant and go to BUSY. The first beat is offered on the next cycle, giving 1 cycle of arbitration latency.
  - BUSY: the datapath is a combinational mux of the granted source:
    - txData/txSOP/txEOP = granted source's signals
    - txValid_out = srcValid_in[grant]
    - srcReady_out[grant] = txReady_in; all other srcReady_out bits are 0
  - On a beat handshake with EOP (valid & ready & EOP): rrPtr = grant+1 mod NUM_SRC.
    - If another request exists, computed with the new rrPtr and excluding nothing, re-grant in the same cycle and stay in BUSY. Back-to-back packets therefore have zero bubble.
    - Otherwise go to IDLE.
- Single-beat packets (SOP & EOP on the same beat) are legal and release the grant on acceptance.
- In IDLE, txValid_out=0, txData_out=0, and all srcReady_out bits are 0.
- While busy, the grant never changes mid-packet, whatever other sources do.
- The granted source may deassert valid mid-packet. The arbiter holds the grant and forwards the bubble (txValid_out=0).
- Protocol errors raise protoErr_out for one cycle:
  - The granted source presents SOP on a beat after the first beat of its packet. The beat is still forwarded unchanged.
  - A non-granted source asserts valid without SOP while no packet of its own is pending. It is not granted and its ready stays 0.
- Reset mid-packet aborts the packet: no EOP is emitted, and the PCIe core is reset alongside.
- busy_out = (state==BUSY).
- grant_out is valid only while busy_out=1; it holds its last value otherwise.

Optional Feature:
Macro TLP_ARB_PRIO0_EN.
- Defined: source 0 has strict priority at every packet boundary. It wins whenever it requests, and round-robin applies only among sources 1..NUM_SRC-1. This is intended for completions, which must never wait behind long DMA streams. A pending source-0 request never preempts a packet already in flight.
- Undefined: pure round-robin over all sources, as described above.

Decomposition:
- Package tlp_arb_pkg:
  - SrcIndex typedef (logic[SRC_BITS-1:0])
  - ArbState enum {IDLE, BUSY}
  - reuses tlp_xcvr_pkg::uint64 for data
- One sub-module, tlp_arb_rr_pick: a purely combinational rotating-priority picker.
  - Inputs: request vector, rrPtr.
  - Outputs: found flag, winner index.
  - Instantiated once. With TLP_ARB_PRIO0_EN, source 0 overrides its output.
- The FSM, grant register and mux live in tlp_tx_arbiter.

Test Plan:
- NUM_SRC=2; src0 sends a 3-beat packet, src1 idle; txReady=1 -> grant=0 next cycle; 3 beats out with SOP on beat 1 and EOP on beat 3; returns to IDLE.
- Both sources hold requests continuously with 2-beat packets -> output packet order 0,1,0,1 with no idle cycle between packets.
- src1 granted; txReady toggles 1,0,1,0; src0 requests mid-packet -> src1 beats stall exactly when ready=0; src0 is granted only after src1's EOP is accepted.
- src0 sends a single-beat packet (SOP=EOP=1) repeatedly while src1 requests -> strict alternation; each packet occupies one beat.
- Granted source raises SOP on beat 2 -> protoErr_out pulses once on that cycle; the beat is forwarded; the grant is unchanged.
- Assert pcieRstN_in low mid-packet -> all outputs are 0 immediately (async); after release, state=IDLE with rrPtr=0.
- With TLP_ARB_PRIO0_EN and NUM_SRC=3, all sources requesting -> order 0,1,0,2,0,1.
